// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
// Feeds VEC_LEN (weight, value) pairs through an external combinational signed
// MAC. The MAC result is registered and fed back as the next cumulative operand.
// One 8-bit result is emitted per run, together with a sticky overflow flag.
//
// Handshake rules, used on both ports:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer must not use ready to decide whether to raise valid.
//   Input port: in_ready is 1 only in ACCUM and does not depend on in_valid.
//   Result port: res_valid is 1 only in DONE. res_data and res_overflow are
//   held stable until res_ready is seen.
module dot_product_sequencer #(
  parameter int VEC_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       float_mode,
  input  logic [7:0] bias,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_weight,
  input  logic [7:0] in_value,
  output logic [7:0] mac_weight,
  output logic [7:0] mac_value,
  output logic [7:0] mac_cumulative,
  output logic       mac_float,
  input  logic [7:0] mac_out,
  input  logic       mac_overflow,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_overflow,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mode_q, mode_d;
  logic            ovf_q, ovf_d;
  logic            pair_accept;

  // Handshake qualifiers and status outputs, all decoded from the state register
  always_comb begin
    in_ready    = (state_q == ST_ACCUM);
    res_valid   = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    pair_accept = in_valid & in_ready;
    dbg_state   = state_q;
  end

  // MAC operand wiring and result outputs. The sequencer never alters mac_out.
  always_comb begin
    mac_weight     = in_weight;
    mac_value      = in_value;
    mac_cumulative = acc_q;
    mac_float      = mode_q;
    res_data       = acc_q;
    res_overflow   = ovf_q;
  end

  // Next-state logic: IDLE waits for start, ACCUM folds pairs in, DONE waits for the consumer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // in_valid is ignored here, so no pair is taken in the start cycle.
        if (start) begin
          acc_d   = bias;
          mode_d  = float_mode;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // start is ignored. Gaps in in_valid simply hold every register.
        if (pair_accept) begin
          acc_d   = mac_out;
          ovf_d   = ovf_q | mac_overflow;
          count_d = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // acc and ovf stay visible after the handshake, until the next start.
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'h00;
      count_q <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Sequencing stage that wraps the combinational signed MAC (signed_multiplier) to compute a VEC_LEN-term dot product plus bias.
- Accepts a stream of (weight, value) pairs over a valid/ready handshake and drives the MAC operand ports.
- Registers the MAC result back as the next cumulative operand, and emits one 8-bit result (int8 or fp8) with a sticky overflow flag over a second valid/ready handshake.

Parameters:
- VEC_LEN, 8, number of (weight, value) pairs per dot product; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new dot product; honoured only in IDLE.
- float_mode  input  1  operand format captured at start: 0 = int8 two's complement, 1 = fp8 (1/4/3, bias 7).
- bias  input  8  initial cumulative value, captured at start.
- in_valid  input  1  pair available.
- in_ready  output  1  sequencer accepts a pair this cycle.
- in_weight  input  8  weight operand.
- in_value  input  8  value operand.
- mac_weight  output  8  to MAC weight; equals in_weight combinationally.
- mac_value  output  8  to MAC value; equals in_value combinationally.
- mac_cumulative  output  8  to MAC cumulative; equals the acc register.
- mac_float  output  1  to MAC float; equals the mode register.
- mac_out  input  8  MAC result.
- mac_overflow  input  1  MAC saturation flag.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_data  output  8  final accumulated value.
- res_overflow  output  1  OR of mac_overflow over all accepted pairs.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; acc, count, mode, ovf all 0.
  - Outputs in reset: in_ready=0, res_valid=0, res_data=0, res_overflow=0, busy=0, mac_cumulative=0, mac_float=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → acc<=bias, mode<=float_mode, count<=0, ovf<=0, next ACCUM.
  - in_valid in IDLE is ignored. No pair is consumed in the same cycle as start.
- ACCUM:
  - in_ready=1.
  - Pair accepted when in_valid & in_ready: acc<=mac_out, ovf<=ovf|mac_overflow, count<=count+1.
  - Accept with count==VEC_LEN-1 → next DONE.
  - in_valid=0 → hold all state; gaps of any length are legal.
  - start is ignored.
- DONE:
  - res_valid=1, res_data=acc, res_overflow=ovf, in_ready=0.
  - res_ready=1 → next IDLE; acc/ovf keep their value until the next start.
  - res_valid, res_data and res_overflow remain stable while res_ready=0.
  - start in DONE is ignored; start in the same cycle as res_ready is also ignored. A new start must arrive in IDLE.
- Latency:
  - start → first in_ready: 1 cycle.
  - Last accept → res_valid: 1 cycle.
  - Minimum run: VEC_LEN+2 cycles from start to IDLE with res_ready held high.
- Arithmetic is performed entirely by the MAC; the sequencer never modifies mac_out.
  - Int8 saturation (0x7F/0x80) passes through unchanged.
- The mode register is used for the whole run; float_mode changes mid-run have no effect.
- count width = $clog2(VEC_LEN+1). VEC_LEN=1 → DONE after the first accept.

Test Plan:
- Int mode, VEC_LEN=4, bias=0x05, pairs (0x02,0x03),(0xFF,0x04),(0x0A,0x02),(0x00,0x07), res_ready=1:
  - acc sequence 0x0B, 0x07, 0x1B, 0x1B.
  - res_data=0x1B, res_overflow=0, res_valid for 1 cycle.
- Int overflow, VEC_LEN=2, bias=0x00, pairs (0x7F,0x7F),(0xFF,0x01):
  - First MAC saturates to 0x7F with overflow; second step gives 0x7E.
  - res_data=0x7E, res_overflow=1 (sticky).
- Float mode, VEC_LEN=4, bias=0x38 (1.0), four pairs (0x40,0x38) (2.0×1.0):
  - acc 3.0, 5.0, 7.0, 9.0.
  - res_data=0x51, mac_float=1 throughout.
- Backpressure and gaps: in_valid low for 3 cycles between pairs 2 and 3; res_ready low for 5 cycles in DONE.
  - State holds during the gap.
  - res_data stable, in_ready=0 throughout, and exactly one result is delivered.
- Reset mid-run: assert rst after 2 of 4 pairs.
  - Immediate IDLE with all outputs 0.
  - A following start with bias=0x00 and 4×(0x01,0x01) gives res_data=0x04.
- Ignored start: pulse start during ACCUM and during DONE.
  - No restart: count and acc unchanged, and the original result is delivered.
